// File: rtl/ls_ex_unit.sv
// Load/store execution unit: runs one LSB memory op as a byte-serial access and broadcasts load results on the LS CDB.
// Optional build macro LS_EX_PERF_CNT_EN adds load_cnt/store_cnt performance counters.
module ls_ex_unit #(
    parameter int ADDR_LEN   = 32,
    parameter int DATA_LEN   = 32,
    parameter int ROB_LEN    = 4,
    parameter int OPENUM_LEN = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ena_from_lsb,
    input  logic [OPENUM_LEN-1:0] openum_from_lsb,
    input  logic [ADDR_LEN-1:0]   mem_addr_from_lsb,
    input  logic [DATA_LEN-1:0]   store_value_from_lsb,
    input  logic [ROB_LEN:0]      rob_id_from_lsb,
    output logic                  busy_to_lsb,
    output logic                  req_to_mem,
    input  logic                  grant_from_mem,
    output logic [ADDR_LEN-1:0]   mem_a,
    output logic [7:0]            mem_dout,
    output logic                  mem_wr,
    input  logic [7:0]            mem_din,
    output logic                  valid_to_cdb,
    output logic [ROB_LEN:0]      rob_id_to_cdb,
    output logic [DATA_LEN-1:0]   result_to_cdb,
`ifdef LS_EX_PERF_CNT_EN
    output logic [31:0]           load_cnt,
    output logic [31:0]           store_cnt,
`endif
    input  logic                  commit_jump_flag_from_rob
);

    localparam logic [OPENUM_LEN-1:0] OPENUM_LB  = OPENUM_LEN'(1);
    localparam logic [OPENUM_LEN-1:0] OPENUM_LH  = OPENUM_LEN'(2);
    localparam logic [OPENUM_LEN-1:0] OPENUM_LW  = OPENUM_LEN'(3);
    localparam logic [OPENUM_LEN-1:0] OPENUM_LBU = OPENUM_LEN'(4);
    localparam logic [OPENUM_LEN-1:0] OPENUM_LHU = OPENUM_LEN'(5);
    localparam logic [OPENUM_LEN-1:0] OPENUM_SB  = OPENUM_LEN'(6);
    localparam logic [OPENUM_LEN-1:0] OPENUM_SH  = OPENUM_LEN'(7);
    localparam logic [OPENUM_LEN-1:0] OPENUM_SW  = OPENUM_LEN'(8);

    typedef enum logic [1:0] {IDLE, ACCESS, WAIT_LAST, DONE} state_t;

    state_t                state, state_nxt;
    logic [OPENUM_LEN-1:0] op_q;
    logic [ADDR_LEN-1:0]   addr_q;
    logic [DATA_LEN-1:0]   data_q;
    logic [DATA_LEN-1:0]   buf_q;
    logic [ROB_LEN:0]      tag_q;
    logic [1:0]            idx_q;
    logic                  cap_pend;
    logic [1:0]            cap_idx;
    logic [1:0]            last_idx;
    logic                  is_load_q;
    logic                  ena_is_load;
    logic                  last_grant;
    logic [DATA_LEN-1:0]   ext;

    assign is_load_q   = (op_q <= OPENUM_LHU);
    assign ena_is_load = (openum_from_lsb <= OPENUM_LHU);
    assign busy_to_lsb = (state != IDLE) | ena_from_lsb;
    assign last_grant  = (state == ACCESS) && grant_from_mem && (idx_q == last_idx);

    always_comb begin
        case (op_q)
            OPENUM_LB, OPENUM_LBU, OPENUM_SB: last_idx = 2'd0;
            OPENUM_LH, OPENUM_LHU, OPENUM_SH: last_idx = 2'd1;
            default:                          last_idx = 2'd3;
        endcase
    end

    always_comb begin
        case (op_q)
            OPENUM_LB:  ext = {{(DATA_LEN-8){buf_q[7]}}, buf_q[7:0]};
            OPENUM_LH:  ext = {{(DATA_LEN-16){buf_q[15]}}, buf_q[15:0]};
            OPENUM_LBU: ext = {{(DATA_LEN-8){1'b0}}, buf_q[7:0]};
            OPENUM_LHU: ext = {{(DATA_LEN-16){1'b0}}, buf_q[15:0]};
            default:    ext = buf_q;
        endcase
    end

    // A flush only kills loads; an in-flight store always runs to its last byte.
    always_comb begin
        state_nxt  = state;
        req_to_mem = 1'b0;
        mem_a      = '0;
        mem_dout   = 8'h00;
        mem_wr     = 1'b0;
        case (state)
            IDLE: begin
                if (ena_from_lsb && !(commit_jump_flag_from_rob && ena_is_load))
                    state_nxt = ACCESS;
            end
            ACCESS: begin
                req_to_mem = 1'b1;
                mem_a      = addr_q + ADDR_LEN'(idx_q);
                mem_wr     = !is_load_q;
                mem_dout   = data_q[{idx_q, 3'b000} +: 8];
                if (is_load_q && commit_jump_flag_from_rob)
                    state_nxt = IDLE;
                else if (last_grant)
                    state_nxt = is_load_q ? WAIT_LAST : IDLE;
            end
            WAIT_LAST: state_nxt = commit_jump_flag_from_rob ? IDLE : DONE;
            DONE:      state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    // Read data lags its grant by one cycle, so captures trail grants through cap_pend/cap_idx.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            op_q          <= '0;
            addr_q        <= '0;
            data_q        <= '0;
            buf_q         <= '0;
            tag_q         <= '0;
            idx_q         <= 2'd0;
            cap_pend      <= 1'b0;
            cap_idx       <= 2'd0;
            valid_to_cdb  <= 1'b0;
            rob_id_to_cdb <= '0;
            result_to_cdb <= '0;
        end else begin
            state        <= state_nxt;
            valid_to_cdb <= 1'b0;
            cap_pend     <= (state == ACCESS) && grant_from_mem && is_load_q && (state_nxt != IDLE);
            cap_idx      <= idx_q;
            if (state == IDLE && state_nxt == ACCESS) begin
                op_q   <= openum_from_lsb;
                addr_q <= mem_addr_from_lsb;
                data_q <= store_value_from_lsb;
                tag_q  <= rob_id_from_lsb;
                idx_q  <= 2'd0;
                buf_q  <= '0;
            end else begin
                if (state == ACCESS && grant_from_mem)
                    idx_q <= idx_q + 2'd1;
                if (cap_pend)
                    buf_q[{cap_idx, 3'b000} +: 8] <= mem_din;
            end
            if (state == DONE && !commit_jump_flag_from_rob) begin
                valid_to_cdb  <= 1'b1;
                rob_id_to_cdb <= tag_q;
                result_to_cdb <= ext;
            end
        end
    end

`ifdef LS_EX_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            load_cnt  <= 32'd0;
            store_cnt <= 32'd0;
        end else begin
            if (state == DONE && !commit_jump_flag_from_rob)
                load_cnt <= load_cnt + 32'd1;
            if (last_grant && !is_load_q)
                store_cnt <= store_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_ls_ex_unit.sv
// Testbench for ls_ex_unit: byte-wide memory responder, transaction-level expectation queues and directed timing checks.
module tb_ls_ex_unit;

    localparam logic [3:0] OP_LB  = 4'd1;
    localparam logic [3:0] OP_LH  = 4'd2;
    localparam logic [3:0] OP_LW  = 4'd3;
    localparam logic [3:0] OP_LBU = 4'd4;
    localparam logic [3:0] OP_LHU = 4'd5;
    localparam logic [3:0] OP_SB  = 4'd6;
    localparam logic [3:0] OP_SH  = 4'd7;
    localparam logic [3:0] OP_SW  = 4'd8;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        ena_from_lsb = 1'b0;
    logic [3:0]  openum_from_lsb = 4'd0;
    logic [31:0] mem_addr_from_lsb = 32'd0;
    logic [31:0] store_value_from_lsb = 32'd0;
    logic [4:0]  rob_id_from_lsb = 5'd0;
    logic        busy_to_lsb;
    logic        req_to_mem;
    logic        grant_from_mem = 1'b1;
    logic [31:0] mem_a;
    logic [7:0]  mem_dout;
    logic        mem_wr;
    logic [7:0]  mem_din = 8'h00;
    logic        valid_to_cdb;
    logic [4:0]  rob_id_to_cdb;
    logic [31:0] result_to_cdb;
    logic        commit_jump_flag_from_rob = 1'b0;
`ifdef LS_EX_PERF_CNT_EN
    logic [31:0] load_cnt;
    logic [31:0] store_cnt;
`endif

    ls_ex_unit #(.ADDR_LEN(32), .DATA_LEN(32), .ROB_LEN(4), .OPENUM_LEN(4)) dut (
        .clk(clk), .rst(rst),
        .ena_from_lsb(ena_from_lsb), .openum_from_lsb(openum_from_lsb),
        .mem_addr_from_lsb(mem_addr_from_lsb), .store_value_from_lsb(store_value_from_lsb),
        .rob_id_from_lsb(rob_id_from_lsb), .busy_to_lsb(busy_to_lsb),
        .req_to_mem(req_to_mem), .grant_from_mem(grant_from_mem),
        .mem_a(mem_a), .mem_dout(mem_dout), .mem_wr(mem_wr), .mem_din(mem_din),
        .valid_to_cdb(valid_to_cdb), .rob_id_to_cdb(rob_id_to_cdb), .result_to_cdb(result_to_cdb),
`ifdef LS_EX_PERF_CNT_EN
        .load_cnt(load_cnt), .store_cnt(store_cnt),
`endif
        .commit_jump_flag_from_rob(commit_jump_flag_from_rob)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        wr;
        logic [31:0] a;
        logic [7:0]  d;
    } acc_t;

    typedef struct {
        logic [4:0]  tag;
        logic [31:0] res;
    } cdb_t;

    logic [7:0] mem [logic [31:0]];
    acc_t       exp_acc[$];
    cdb_t       exp_cdb[$];
    int         n_checks = 0;
    int         n_pass = 0;
    logic [7:0] next_din = 8'h00;
    logic       have_din = 1'b0;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    function automatic logic [7:0] mem_rd(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return 8'h00;
    endfunction

    function automatic int nbytes(input logic [3:0] op);
        case (op)
            OP_LB, OP_LBU, OP_SB: return 1;
            OP_LH, OP_LHU, OP_SH: return 2;
            default:              return 4;
        endcase
    endfunction

    // Architectural load result straight from the byte memory and the extension rule.
    function automatic logic [31:0] model_load(input logic [3:0] op, input logic [31:0] a);
        logic [31:0] raw;
        raw = 32'd0;
        for (int i = 0; i < nbytes(op); i++) raw = raw | (32'(mem_rd(a + 32'(i))) << (8 * i));
        case (op)
            OP_LB:   return 32'($signed(raw[7:0]));
            OP_LH:   return 32'($signed(raw[15:0]));
            default: return raw;
        endcase
    endfunction

    // Memory responder: writes land at the grant, read data appears in the following cycle.
    always @(negedge clk) begin
        if (req_to_mem && grant_from_mem) begin
            if (mem_wr) mem[mem_a] = mem_dout;
            else begin
                next_din = mem_rd(mem_a);
                have_din = 1'b1;
            end
        end
    end

    always @(posedge clk) begin
        #1;
        mem_din  = have_din ? next_din : 8'hA5;
        have_din = 1'b0;
    end

    always @(negedge clk) begin
        if (req_to_mem && grant_from_mem) begin
            checkOutput("access_expected", 64'(exp_acc.size() != 0), 64'd1);
            if (exp_acc.size() != 0) begin
                acc_t e;
                e = exp_acc.pop_front();
                checkOutput("access_addr_wr", {mem_wr, mem_a}, {e.wr, e.a});
                if (e.wr) checkOutput("access_wdata", 64'(mem_dout), 64'(e.d));
            end
        end
        if (!req_to_mem)
            checkOutput("idle_bus_zero", {mem_wr, mem_a, mem_dout}, 64'd0);
        if (valid_to_cdb) begin
            checkOutput("cdb_expected", 64'(exp_cdb.size() != 0), 64'd1);
            if (exp_cdb.size() != 0) begin
                cdb_t c;
                c = exp_cdb.pop_front();
                checkOutput("cdb_tag_result", {rob_id_to_cdb, result_to_cdb}, {c.tag, c.res});
            end
        end
    end

    task automatic applyStimulus(input logic [3:0] op, input logic [31:0] a, input logic [31:0] d,
                                 input logic [4:0] tag, input int exp_n, input bit exp_pulse);
        for (int i = 0; i < exp_n; i++) begin
            acc_t e;
            e.wr = (op >= OP_SB);
            e.a  = a + 32'(i);
            e.d  = d[8*i +: 8];
            exp_acc.push_back(e);
        end
        if (exp_pulse) begin
            cdb_t c;
            c.tag = tag;
            c.res = model_load(op, a);
            exp_cdb.push_back(c);
        end
        @(negedge clk);
        ena_from_lsb         = 1'b1;
        openum_from_lsb      = op;
        mem_addr_from_lsb    = a;
        store_value_from_lsb = d;
        rob_id_from_lsb      = tag;
        @(posedge clk);
        #1;
        ena_from_lsb = 1'b0;
    endtask

    task automatic waitValid(output int m);
        m = -1;
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk);
            if (valid_to_cdb) begin
                m = i;
                break;
            end
        end
    endtask

    task automatic waitIdle();
        int i;
        for (i = 0; i < 30; i++) begin
            @(negedge clk);
            if (!busy_to_lsb) break;
        end
        checkOutput("idle_within_bound", 64'(i < 30), 64'd1);
    endtask

    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int m;
        int pulses;
        mem[32'h1000] = 8'h11; mem[32'h1001] = 8'h22; mem[32'h1002] = 8'h33; mem[32'h1003] = 8'h44;
        mem[32'h20]   = 8'h80;
        mem[32'h50]   = 8'h34; mem[32'h51]   = 8'h92;

        repeat (2) @(negedge clk);
        checkOutput("reset_outputs", {busy_to_lsb, req_to_mem, mem_wr, valid_to_cdb, rob_id_to_cdb, result_to_cdb}, 64'd0);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        $display("[TB] LW with continuous grant");
        grant_from_mem = 1'b1;
        applyStimulus(OP_LW, 32'h1000, 32'hCAFE_F00D, 5'd5, 4, 1'b1);
        @(negedge clk);
        checkOutput("lw_first_addr", {req_to_mem, mem_a}, {1'b1, 32'h1000});
        waitValid(m);
        checkOutput("lw_pulse_cycle", 64'(m + 1), 64'd7);
        checkOutput("lw_result", {rob_id_to_cdb, result_to_cdb}, {5'd5, 32'h4433_2211});
        checkOutput("lw_busy_low", 64'(busy_to_lsb), 64'd0);
        @(negedge clk);
        checkOutput("lw_pulse_single", 64'(valid_to_cdb), 64'd0);

        $display("[TB] LB and LBU");
        applyStimulus(OP_LB, 32'h20, 32'd0, 5'd3, 1, 1'b1);
        waitValid(m);
        checkOutput("lb_pulse_cycle", 64'(m), 64'd4);
        checkOutput("lb_result", 64'(result_to_cdb), 64'hFFFF_FF80);
        applyStimulus(OP_LBU, 32'h20, 32'd0, 5'd4, 1, 1'b1);
        waitValid(m);
        checkOutput("lbu_result", 64'(result_to_cdb), 64'h0000_0080);

        $display("[TB] SH with stalled grant");
        applyStimulus(OP_SH, 32'h40, 32'h0000_BEEF, 5'd6, 2, 1'b0);
        @(negedge clk);
        checkOutput("sh_byte0", {req_to_mem, mem_wr, mem_a, mem_dout}, {1'b1, 1'b1, 32'h40, 8'hEF});
        stepCycle();
        grant_from_mem = 1'b0;
        @(negedge clk);
        checkOutput("sh_stall_hold", {req_to_mem, mem_wr, mem_a, mem_dout}, {1'b1, 1'b1, 32'h41, 8'hBE});
        stepCycle();
        grant_from_mem = 1'b1;
        @(negedge clk);
        checkOutput("sh_busy_during", 64'(busy_to_lsb), 64'd1);
        stepCycle();
        @(negedge clk);
        checkOutput("sh_idle_after", {busy_to_lsb, req_to_mem, mem_wr}, 64'd0);

        $display("[TB] LH flushed in WAIT_LAST");
        applyStimulus(OP_LH, 32'h50, 32'd0, 5'd8, 2, 1'b0);
        stepCycle();
        stepCycle();
        commit_jump_flag_from_rob = 1'b1;
        @(negedge clk);
        checkOutput("lh_flush_busy", 64'(busy_to_lsb), 64'd1);
        stepCycle();
        commit_jump_flag_from_rob = 1'b0;
        @(negedge clk);
        checkOutput("lh_flush_idle", 64'(busy_to_lsb), 64'd0);
        pulses = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (valid_to_cdb) pulses++;
        end
        checkOutput("lh_flush_no_pulse", 64'(pulses), 64'd0);

        $display("[TB] SW ignores flush");
        applyStimulus(OP_SW, 32'h60, 32'hDEAD_BEEF, 5'd7, 4, 1'b0);
        stepCycle();
        commit_jump_flag_from_rob = 1'b1;
        stepCycle();
        commit_jump_flag_from_rob = 1'b0;
        @(negedge clk);
        checkOutput("sw_flush_still_busy", {busy_to_lsb, req_to_mem}, {1'b1, 1'b1});
        stepCycle();
        stepCycle();
        @(negedge clk);
        checkOutput("sw_flush_idle", 64'(busy_to_lsb), 64'd0);

        $display("[TB] Flush in IDLE");
        commit_jump_flag_from_rob = 1'b1;
        applyStimulus(OP_LB, 32'h20, 32'd0, 5'd9, 0, 1'b0);
        commit_jump_flag_from_rob = 1'b0;
        @(negedge clk);
        checkOutput("idle_flush_drops_load", {busy_to_lsb, req_to_mem}, 64'd0);
        commit_jump_flag_from_rob = 1'b1;
        applyStimulus(OP_SB, 32'h70, 32'h0000_005A, 5'd10, 1, 1'b0);
        commit_jump_flag_from_rob = 1'b0;
        @(negedge clk);
        checkOutput("idle_flush_keeps_store", {req_to_mem, mem_wr, mem_a}, {1'b1, 1'b1, 32'h70});
        waitIdle();

        $display("[TB] Reset mid-LW");
        applyStimulus(OP_LW, 32'h1000, 32'd0, 5'd11, 2, 1'b0);
        stepCycle();
        stepCycle();
        checkOutput("rst_mid_byte2", {req_to_mem, mem_a}, {1'b1, 32'h1002});
        rst = 1'b0;
        #1;
        checkOutput("rst_mid_outputs", {busy_to_lsb, req_to_mem, mem_wr, mem_dout, valid_to_cdb, rob_id_to_cdb, result_to_cdb}, 64'd0);
        checkOutput("rst_mid_addr", 64'(mem_a), 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;

        $display("[TB] Post-reset mix");
        applyStimulus(OP_LBU, 32'h20, 32'd0, 5'd12, 1, 1'b1);
        waitValid(m);
        checkOutput("post_rst_lbu", {rob_id_to_cdb, result_to_cdb}, {5'd12, 32'h0000_0080});
        applyStimulus(OP_LH, 32'h50, 32'd0, 5'd13, 2, 1'b1);
        waitValid(m);
        checkOutput("lh_result", 64'(result_to_cdb), 64'hFFFF_9234);
        checkOutput("lh_pulse_cycle", 64'(m), 64'd5);
        applyStimulus(OP_LW, 32'h1000, 32'd0, 5'd14, 4, 1'b1);
        waitValid(m);
        applyStimulus(OP_SB, 32'h80, 32'h0000_0011, 5'd15, 1, 1'b0);
        waitIdle();
        applyStimulus(OP_SW, 32'h84, 32'h0102_0304, 5'd16, 4, 1'b0);
        waitIdle();
        applyStimulus(OP_LHU, 32'h50, 32'd0, 5'd17, 1, 1'b0);
        commit_jump_flag_from_rob = 1'b1;
        stepCycle();
        commit_jump_flag_from_rob = 1'b0;
        @(negedge clk);
        checkOutput("access_flush_idle", 64'(busy_to_lsb), 64'd0);
        repeat (6) @(negedge clk);

`ifdef LS_EX_PERF_CNT_EN
        checkOutput("load_cnt", 64'(load_cnt), 64'd3);
        checkOutput("store_cnt", 64'(store_cnt), 64'd2);
`endif

        checkOutput("mem_sh", {mem_rd(32'h41), mem_rd(32'h40)}, 64'hBEEF);
        checkOutput("mem_sw_flush", {mem_rd(32'h63), mem_rd(32'h62), mem_rd(32'h61), mem_rd(32'h60)}, 64'hDEAD_BEEF);
        checkOutput("mem_sb_idle_flush", 64'(mem_rd(32'h70)), 64'h5A);
        checkOutput("mem_sw", {mem_rd(32'h87), mem_rd(32'h86), mem_rd(32'h85), mem_rd(32'h84), mem_rd(32'h80)}, 64'h01_0203_0411);
        checkOutput("acc_queue_drained", 64'(exp_acc.size()), 64'd0);
        checkOutput("cdb_queue_drained", 64'(exp_cdb.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
